// File: rtl/cpu_pkg.sv
// Shared CPU package: default datapath widths, the hardwired-zero register
// index and the ALU control encodings used across the single-cycle datapath.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110
    } alu_ctrl_e;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file: index mux, index-0
// override and the optional write-through forward.
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data.
module regfile_read_port
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              reset,
    input  logic [ADDR_W-1:0] read_reg,
    input  logic [DATA_W-1:0] mem [1 << ADDR_W],
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

`ifdef REGFILE_BYPASS_EN
    localparam logic BYPASS_EN = 1'b1;
`else
    localparam logic BYPASS_EN = 1'b0;
`endif

    logic fwd_hit_s;

    // Forward only a real (non-zero, non-reset) write aimed at this index.
    always_comb begin
        fwd_hit_s = 1'b0;
        if (BYPASS_EN && !reset && reg_write &&
            (write_reg != ZERO_IDX) && (write_reg == read_reg)) begin
            fwd_hit_s = 1'b1;
        end else begin
            fwd_hit_s = 1'b0;
        end
    end

    // Select the read value: zero index wins, then forward, then storage.
    always_comb begin
        read_data = {DATA_W{1'b0}};
        if (read_reg == ZERO_IDX) begin
            read_data = {DATA_W{1'b0}};
        end else if (fwd_hit_s) begin
            read_data = write_data;
        end else begin
            read_data = mem[read_reg];
        end
    end

endmodule

// File: rtl/regfile.sv
// Architectural register file: 2^ADDR_W x DATA_W, two combinational read
// ports, one synchronous write port, register 0 hardwired to zero, and an
// asynchronous active-high reset that clears every entry.
// Build option: REGFILE_BYPASS_EN enables write-through forwarding.
module regfile
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  we_s;

    // One-hot write decode; writes aimed at index 0 are dropped here.
    always_comb begin
        we_s = {DEPTH{1'b0}};
        if (reg_write && (write_reg != ZERO_IDX)) begin
            we_s[write_reg] = 1'b1;
        end else begin
            we_s = {DEPTH{1'b0}};
        end
    end

    // Storage: reset clears all entries and overrides a coincident write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (we_s[i]) begin
                    mem_r[i] <= write_data;
                end
            end
        end
    end

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port1 (
        .reset      (reset),
        .read_reg   (read_reg1),
        .mem        (mem_r),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_data  (read_data1)
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port2 (
        .reset      (reset),
        .read_reg   (read_reg2),
        .mem        (mem_r),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_data  (read_data2)
    );

endmodule

// File: doc/regfile.md
# regfile

Architectural register file for the single-cycle datapath: 32 general-purpose registers of 32 bits. It sits directly upstream of the ALU and drives the ALU's two operand inputs, `a1` and `a2`. It also drives the store-data path. Register 0 is hardwired to zero.

## Interface
Parameters:
- `DATA_W`, 32: register width in bits; matches the ALU operand width.
- `ADDR_W`, 5: register index width; depth is 2^ADDR_W.

Ports:
- `clk`  input  1  sole clock; all writes occur on its rising edge.
- `reset`  input  1  asynchronous, active-high; clears every register.
- `read_reg1`  input  ADDR_W  index for port 1.
- `read_reg2`  input  ADDR_W  index for port 2.
- `read_data1`  output  DATA_W  contents of `read_reg1`; feeds ALU `a1`.
- `read_data2`  output  DATA_W  contents of `read_reg2`; feeds ALU `a2` via the ALUSrc mux and the store-data path.
- `reg_write`  input  1  write enable.
- `write_reg`  input  ADDR_W  destination index.
- `write_data`  input  DATA_W  value to write (ALU `Aout` or load data).

## Operation
- Storage: 2^ADDR_W words of DATA_W bits.
  - Entry 0 is never written; reads of index 0 always return 0.
- Write:
  - Occurs on a `clk` rising edge when `reg_write`=1 and `write_reg`≠0.
  - `mem[write_reg]` ← `write_data`.
- Write to index 0 with `reg_write`=1: silently dropped; no state changes.
- Reads are combinational, with no latency: `read_dataN` = `mem[read_regN]`.
- Both ports may address the same register. Both return the identical value.
- Reset:
  - While `reset`=1, all entries are 0, independent of `clk`.
  - Writes are blocked during reset, including on a clock edge coincident with reset.
  - Reads during reset return 0.
- Reset deasserted mid-program: the first write is accepted on the first rising edge after `reset` falls.
- No X propagation:
  - Every entry has a defined reset value.
  - Read indices are fully decoded; no out-of-range index exists at the default parameters.

## Timing
- Read latency 0 cycles (combinational from `read_regN` and state).
- Write latency 1 edge. Data written at edge k is visible on the read ports after edge k, without the bypass feature.
- All outputs read 0 while `reset`=1.
- Same-cycle read and write to the same index:
  - Without `REGFILE_BYPASS_EN`: the read returns the old value until the edge.
  - With it: see Configuration.
- No handshake. Control inputs are sampled only at the rising edge of `clk`.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined: write-through forwarding is enabled. When all of the following hold, `read_dataN` = `write_data` combinationally in the same cycle:
  - `reg_write`=1
  - `write_reg`≠0
  - `write_reg`=`read_regN`
  - `reset`=0
- Not defined: no forwarding. Reads reflect stored state only.
- The feature exists so the file can be reused unchanged when the datapath is pipelined.
- Index 0 is never forwarded in either build.

## Structure
- Shared package `cpu_pkg` holds:
  - Width constants `DATA_W`/`ADDR_W` defaults and `REG_ZERO` (index 0).
  - The ALU control encodings: AND 4'b0000, OR 4'b0001, add 4'b0010, sub 4'b0110.
- The regfile imports width constants from `cpu_pkg` only.
- One sub-module, `regfile_read_port`, is instantiated twice. It contains:
  - the index mux
  - the zero-index override
  - the conditional bypass compare/select
- The top level holds storage, write decode and reset.

## Test plan
- Reset: hold `reset`=1, sweep `read_reg1`/`read_reg2` across 0..31 → all reads 0. Pulse `clk` with `reg_write`=1, `write_reg`=5, `write_data`=32'hDEADBEEF → r5 still 0 after release.
- Basic write/read:
  - Write r7=32'h0000_1234 at edge 1 and r8=32'hFFFF_FFFF at edge 2.
  - Read r7 on port1 and r8 on port2 → 32'h0000_1234 and 32'hFFFF_FFFF.
  - Feeding these into ALU sub gives `Aout`=32'h0000_1235.
- Zero register: write r0=32'hA5A5A5A5 → `read_data1` with `read_reg1`=0 returns 0 in both builds, including same-cycle.
- Same-cycle hazard: r3 holds 32'h11, then write r3=32'h22 with `read_reg2`=3 in the same cycle:
  - Before the edge: 32'h11 without the macro, 32'h22 with it.
  - After the edge: 32'h22 in both builds.
- Async reset mid-run: fill r1..r31 with their index, assert `reset` between edges → all reads drop to 0 immediately, without waiting for a clock edge. After release, write r31=32'h1 → only r31 is nonzero.
- Dual port same index: write r12=32'hCAFE_F00D, set `read_reg1`=`read_reg2`=12 → both ports return 32'hCAFE_F00D.
